crc16_block_checker: RTL and testbench
======================================

# crc16_block_checker

- Receive-side CRC-16 checker for SD data blocks in the SPI_SD path.
- Consumes a byte stream: BLOCK_LEN payload bytes followed by the card's two CRC bytes, MSB first.
- Recomputes CRC-16/CCITT (polynomial 0x1021, initial value 0x0000, MSB-first, no reflection, no final XOR) and flags match or mismatch.
- Sits between the SPI byte receiver and the SD controller / CPU peripheral wrapper.

## Interface

Parameters:
- BLOCK_LEN, 512, payload bytes per block (legal range 1..4096).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; arms a new block. Honoured only in IDLE or DONE.
- byte_in  in  8  received byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  checker can accept a byte this cycle.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  level; high in DONE.
- crc_ok  out  1  valid while done: crc_calc == crc_rx.
- crc_calc  out  16  running / final computed CRC.
- crc_rx  out  16  CRC received from the stream.
- byte_count  out  13  payload bytes accepted so far.

## Operation

- Transfer rule: a byte is transferred only on a cycle where byte_valid && byte_ready.
- FSM states: IDLE, WAIT_DATA, SHIFT, WAIT_CRC_HI, WAIT_CRC_LO, CHECK, DONE.
- IDLE / DONE:
  - byte_ready=0; byte_valid is ignored.
  - start clears crc_calc, crc_rx, byte_count, done and crc_ok, then moves to WAIT_DATA.
- WAIT_DATA:
  - byte_ready=1.
  - On transfer: latch byte_in into the shift register, increment byte_count, go to SHIFT.
- SHIFT:
  - byte_ready=0.
  - One bit per cycle, MSB first, for 8 cycles, driven by a 3-bit counter.
  - Per-bit update: fb = crc[15] ^ bit; crc = {crc[14:0],1'b0} ^ (fb ? 16'h1021 : 0).
  - After the 8th bit: go to WAIT_CRC_HI if byte_count == BLOCK_LEN, else WAIT_DATA.
- WAIT_CRC_HI: byte_ready=1; on transfer, crc_rx[15:8] = byte_in, go to WAIT_CRC_LO. CRC bytes never enter the CRC computation.
- WAIT_CRC_LO: byte_ready=1; on transfer, crc_rx[7:0] = byte_in, go to CHECK.
- CHECK: one cycle; register crc_ok = (crc_calc == crc_rx); go to DONE.
- DONE: done=1 and crc_ok hold until the next start or reset.
- Boundary behaviour:
  - start while busy is ignored; the block in progress continues.
  - start and byte_valid in the same cycle from DONE: start wins and the byte is not consumed (byte_ready=0 that cycle).
  - Reset mid-block aborts immediately. No partial result survives.
  - byte_count saturates only at BLOCK_LEN, by construction.
- Reset values: state=IDLE, byte_ready=0, busy=0, done=0, crc_ok=0, crc_calc=0, crc_rx=0, byte_count=0.

## Timing

- start at edge N puts the block in WAIT_DATA after edge N; byte_ready is high from cycle N+1.
- Serial build:
  - Each payload byte costs 9 cycles (1 accept + 8 SHIFT).
  - Peak rate is 1 byte per 9 clocks.
  - The SPI receiver must run at least 9 clk per byte or hold byte_valid.
- CRC bytes are accepted at 1 per cycle.
- done rises 2 edges after the CRC low-byte transfer (CHECK, then DONE).
- crc_calc is final from the edge that ends the last SHIFT cycle.
- The output values above are registered.

## Configuration

- CRC16_BYTE_PARALLEL_EN defined:
  - SHIFT is never entered.
  - The 8-bit unrolled CRC update is applied in the WAIT_DATA transfer cycle.
  - byte_ready stays high through the whole payload; throughput is 1 byte/clock.
  - done follows the last CRC byte by the same 2 edges.
- Undefined: the bit-serial 9-cycle path above (smaller area).
- Results must be bit-identical in both builds.

## Test plan

- Reset: assert rst low mid-SHIFT -> all outputs return to reset values immediately; start after release runs cleanly.
- BLOCK_LEN=9, payload "123456789" (0x31..0x39), CRC bytes 0x31, 0xC3 -> crc_calc=0x31C3, done=1, crc_ok=1.
- BLOCK_LEN=512, 512×0xFF, CRC bytes 0x7F, 0xA1 -> crc_calc=0x7FA1, crc_ok=1.
- Same stream with CRC low byte 0xA0 -> crc_rx=0x7FA0, done=1, crc_ok=0.
- BLOCK_LEN=1, byte 0x01 with byte_valid held high continuously -> exactly 3 transfers (0x01, then 0x10, 0x21 as CRC); crc_calc=0x1021, crc_ok=1. In the serial build byte_ready is low for 8 cycles after the first transfer.
- start pulsed mid-payload -> ignored, byte_count keeps counting; start in DONE -> crc_calc, crc_rx, byte_count and done clear, byte_ready high next cycle.

Source files
------------

// File: rtl/crc16_block_checker_if.sv
// rtl/crc16_block_checker_if.sv - byte stream handshake between the SPI byte receiver and the CRC-16 checker
interface crc16_block_checker_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready
    );
endinterface

// File: rtl/crc16_block_checker.sv
// rtl/crc16_block_checker.sv - SD data block CRC-16/CCITT receive checker (CRC16_BYTE_PARALLEL_EN selects 1 byte/clock update)
module crc16_block_checker #(
    parameter int BLOCK_LEN = 512
) (
    input  logic                         clk,
    input  logic                         rst,
    crc16_block_checker_if.slave         bus,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         crc_ok,
    output logic [15:0]                  crc_calc,
    output logic [15:0]                  crc_rx,
    output logic [12:0]                  byte_count
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DATA,
        SHIFT,
        WAIT_CRC_HI,
        WAIT_CRC_LO,
        CHECK,
        DONE
    } state_t;

    localparam logic [12:0] LAST_BYTE = 13'(BLOCK_LEN);

    state_t state;
    logic   ready_q;
    logic   xfer;

`ifndef CRC16_BYTE_PARALLEL_EN
    logic [7:0] shift_reg;
    logic [2:0] bit_cnt;
`endif

    assign bus.byte_ready = ready_q;
    assign xfer           = bus.byte_valid && ready_q;

    function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

`ifdef CRC16_BYTE_PARALLEL_EN
    // Unrolled form of eight serial steps, so both builds agree bit for bit.
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            r = crc_bit(r, d[i]);
        end
        return r;
    endfunction
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ready_q    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            crc_ok     <= 1'b0;
            crc_calc   <= 16'h0000;
            crc_rx     <= 16'h0000;
            byte_count <= 13'd0;
`ifndef CRC16_BYTE_PARALLEL_EN
            shift_reg  <= 8'h00;
            bit_cnt    <= 3'd0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    // byte_ready is low here, so a byte offered alongside start is left untouched.
                    if (start) begin
                        crc_calc   <= 16'h0000;
                        crc_rx     <= 16'h0000;
                        byte_count <= 13'd0;
                        done       <= 1'b0;
                        crc_ok     <= 1'b0;
                        busy       <= 1'b1;
                        ready_q    <= 1'b1;
                        state      <= WAIT_DATA;
                    end
                end

                WAIT_DATA: begin
                    if (xfer) begin
                        byte_count <= byte_count + 13'd1;
`ifdef CRC16_BYTE_PARALLEL_EN
                        crc_calc <= crc_byte(crc_calc, bus.byte_in);
                        if (byte_count + 13'd1 == LAST_BYTE) begin
                            state <= WAIT_CRC_HI;
                        end
`else
                        shift_reg <= bus.byte_in;
                        bit_cnt   <= 3'd0;
                        ready_q   <= 1'b0;
                        state     <= SHIFT;
`endif
                    end
                end

`ifndef CRC16_BYTE_PARALLEL_EN
                SHIFT: begin
                    crc_calc  <= crc_bit(crc_calc, shift_reg[7]);
                    shift_reg <= {shift_reg[6:0], 1'b0};
                    bit_cnt   <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        ready_q <= 1'b1;
                        state   <= (byte_count == LAST_BYTE) ? WAIT_CRC_HI : WAIT_DATA;
                    end
                end
`endif

                // The card's CRC bytes are captured only; they never feed crc_calc.
                WAIT_CRC_HI: begin
                    if (xfer) begin
                        crc_rx[15:8] <= bus.byte_in;
                        state        <= WAIT_CRC_LO;
                    end
                end

                WAIT_CRC_LO: begin
                    if (xfer) begin
                        crc_rx[7:0] <= bus.byte_in;
                        ready_q     <= 1'b0;
                        state       <= CHECK;
                    end
                end

                CHECK: begin
                    crc_ok <= (crc_calc == crc_rx);
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= DONE;
                end

                default: begin
                    ready_q <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc16_block_checker.sv
// tb/tb_crc16_block_checker.sv - directed bench for crc16_block_checker with BLOCK_LEN 9, 512 and 1
module tb_crc16_block_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic [1:0] sel;

    int errors = 0;
    int checks = 0;
    int timeouts = 0;
    int xfer_cnt = 0;

    always #5 clk = ~clk;

    crc16_block_checker_if bus9 ();
    crc16_block_checker_if bus512 ();
    crc16_block_checker_if bus1 ();

    logic        ready_a [3];
    logic        busy_a  [3];
    logic        done_a  [3];
    logic        ok_a    [3];
    logic [15:0] calc_a  [3];
    logic [15:0] rx_a    [3];
    logic [12:0] count_a [3];

    assign bus9.byte_in     = byte_in;
    assign bus512.byte_in   = byte_in;
    assign bus1.byte_in     = byte_in;
    assign bus9.byte_valid   = byte_valid && (sel == 2'd0);
    assign bus512.byte_valid = byte_valid && (sel == 2'd1);
    assign bus1.byte_valid   = byte_valid && (sel == 2'd2);
    assign ready_a[0] = bus9.byte_ready;
    assign ready_a[1] = bus512.byte_ready;
    assign ready_a[2] = bus1.byte_ready;

    crc16_block_checker #(.BLOCK_LEN(9)) dut9 (
        .clk(clk), .rst(rst_n), .bus(bus9), .start(start && (sel == 2'd0)),
        .busy(busy_a[0]), .done(done_a[0]), .crc_ok(ok_a[0]),
        .crc_calc(calc_a[0]), .crc_rx(rx_a[0]), .byte_count(count_a[0])
    );

    crc16_block_checker #(.BLOCK_LEN(512)) dut512 (
        .clk(clk), .rst(rst_n), .bus(bus512), .start(start && (sel == 2'd1)),
        .busy(busy_a[1]), .done(done_a[1]), .crc_ok(ok_a[1]),
        .crc_calc(calc_a[1]), .crc_rx(rx_a[1]), .byte_count(count_a[1])
    );

    crc16_block_checker #(.BLOCK_LEN(1)) dut1 (
        .clk(clk), .rst(rst_n), .bus(bus1), .start(start && (sel == 2'd2)),
        .busy(busy_a[2]), .done(done_a[2]), .crc_ok(ok_a[2]),
        .crc_calc(calc_a[2]), .crc_rx(rx_a[2]), .byte_count(count_a[2])
    );

    logic        ready_m, busy_m, done_m, ok_m;
    logic [15:0] calc_m, rx_m;
    logic [12:0] count_m;

    assign ready_m = ready_a[sel];
    assign busy_m  = busy_a[sel];
    assign done_m  = done_a[sel];
    assign ok_m    = ok_a[sel];
    assign calc_m  = calc_a[sel];
    assign rx_m    = rx_a[sel];
    assign count_m = count_a[sel];

    always @(posedge clk) begin
        if (byte_valid && ready_m === 1'b1) xfer_cnt <= xfer_cnt + 1;
    end

    // All tasks enter and leave on a falling edge.
    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        byte_in    = b;
        byte_valid = 1'b1;
        n = 0;
        while (ready_m !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (ready_m !== 1'b1) timeouts++;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic wait_done;
        int n;
        n = 0;
        while (done_m !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (done_m !== 1'b1) timeouts++;
    endtask

    task automatic test_reset;
        sel = 2'd0;
        checks++; if ({ready_m, busy_m, done_m, ok_m} !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {ready_m, busy_m, done_m, ok_m}); end
        checks++; if ({calc_m, rx_m, count_m} !== 45'd0) begin errors++; $display("FAIL reset_values got=%h/%h/%0d exp=0/0/0", calc_m, rx_m, count_m); end
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        send_byte(8'h31);
        send_byte(8'h32);
        repeat (3) @(negedge clk);
        checks++; if (busy_m !== 1'b1 || count_m !== 13'd2) begin errors++; $display("FAIL pre_reset_busy got=%b/%0d exp=1/2", busy_m, count_m); end
        rst_n = 1'b0;
        #1;
        checks++; if ({ready_m, busy_m, done_m, ok_m} !== 4'b0000) begin errors++; $display("FAIL midblock_reset_flags got=%b exp=0000", {ready_m, busy_m, done_m, ok_m}); end
        checks++; if ({calc_m, rx_m, count_m} !== 45'd0) begin errors++; $display("FAIL midblock_reset_values got=%h/%h/%0d exp=0/0/0", calc_m, rx_m, count_m); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_check_vector;
        logic [7:0] msg [9];
        for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);
        sel = 2'd0;
        pulse_start();
        checks++; if (ready_m !== 1'b1 || busy_m !== 1'b1) begin errors++; $display("FAIL vec_armed got=%b%b exp=11", ready_m, busy_m); end
        for (int i = 0; i < 9; i++) send_byte(msg[i]);
        checks++; if (count_m !== 13'd9) begin errors++; $display("FAIL vec_count got=%0d exp=9", count_m); end
        send_byte(8'h31);
        send_byte(8'hC3);
        checks++; if (done_m !== 1'b0) begin errors++; $display("FAIL vec_done_early got=%b exp=0", done_m); end
        wait_done();
        checks++; if (done_m !== 1'b1 || ok_m !== 1'b1) begin errors++; $display("FAIL vec_result got=%b%b exp=11", done_m, ok_m); end
        checks++; if (calc_m !== 16'h31C3 || rx_m !== 16'h31C3) begin errors++; $display("FAIL vec_crc got=%h/%h exp=31c3/31c3", calc_m, rx_m); end
    endtask

    task automatic test_start_ignored;
        logic [7:0] msg [9];
        for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);
        sel = 2'd0;
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(msg[i]);
        pulse_start();
        checks++; if (busy_m !== 1'b1 || count_m !== 13'd4) begin errors++; $display("FAIL busy_start got=%b/%0d exp=1/4", busy_m, count_m); end
        send_byte(msg[4]);
        checks++; if (count_m !== 13'd5) begin errors++; $display("FAIL busy_start_count got=%0d exp=5", count_m); end
        for (int i = 5; i < 9; i++) send_byte(msg[i]);
        send_byte(8'h31);
        send_byte(8'hC3);
        wait_done();
        checks++; if (ok_m !== 1'b1 || calc_m !== 16'h31C3) begin errors++; $display("FAIL busy_start_result got=%b/%h exp=1/31c3", ok_m, calc_m); end
    endtask

    task automatic test_restart_from_done;
        sel = 2'd0;
        checks++; if (done_m !== 1'b1) begin errors++; $display("FAIL restart_pre_done got=%b exp=1", done_m); end
        byte_in    = 8'hAA;
        byte_valid = 1'b1;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (ready_m !== 1'b1 || busy_m !== 1'b1 || done_m !== 1'b0) begin errors++; $display("FAIL restart_flags got=%b%b%b exp=110", ready_m, busy_m, done_m); end
        checks++; if (count_m !== 13'd0) begin errors++; $display("FAIL restart_byte_consumed got=%0d exp=0", count_m); end
        checks++; if (calc_m !== 16'h0000 || rx_m !== 16'h0000 || ok_m !== 1'b0) begin errors++; $display("FAIL restart_clear got=%h/%h/%b exp=0/0/0", calc_m, rx_m, ok_m); end
        byte_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_512(input logic [7:0] lo, input logic exp_ok);
        sel = 2'd1;
        pulse_start();
        for (int i = 0; i < 512; i++) send_byte(8'hFF);
        checks++; if (count_m !== 13'd512) begin errors++; $display("FAIL ff_count got=%0d exp=512", count_m); end
        send_byte(8'h7F);
        send_byte(lo);
        wait_done();
        checks++; if (calc_m !== 16'h7FA1) begin errors++; $display("FAIL ff_calc got=%h exp=7fa1", calc_m); end
        checks++; if (rx_m !== {8'h7F, lo}) begin errors++; $display("FAIL ff_rx got=%h exp=%h", rx_m, {8'h7F, lo}); end
        checks++; if (done_m !== 1'b1 || ok_m !== exp_ok) begin errors++; $display("FAIL ff_ok got=%b%b exp=1%b", done_m, ok_m, exp_ok); end
    endtask

    task automatic test_all_ff;
        run_512(8'hA1, 1'b1);
        run_512(8'hA0, 1'b0);
    endtask

    task automatic test_held_valid;
        logic [7:0] seq [4];
        int base, k, idx, low;
        seq[0] = 8'h01; seq[1] = 8'h10; seq[2] = 8'h21; seq[3] = 8'h55;
        sel = 2'd2;
        pulse_start();
        base = xfer_cnt;
        idx  = 0;
        low  = 0;
        byte_in    = seq[0];
        byte_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            k = xfer_cnt - base;
            if (k > idx && k < 4) begin
                idx = k;
                byte_in = seq[k];
            end
            if (k == 1 && ready_m === 1'b0) low++;
        end
        byte_valid = 1'b0;
        checks++; if (xfer_cnt - base !== 3) begin errors++; $display("FAIL held_transfers got=%0d exp=3", xfer_cnt - base); end
`ifdef CRC16_BYTE_PARALLEL_EN
        checks++; if (low !== 0) begin errors++; $display("FAIL held_ready_low got=%0d exp=0", low); end
`else
        checks++; if (low !== 8) begin errors++; $display("FAIL held_ready_low got=%0d exp=8", low); end
`endif
        checks++; if (calc_m !== 16'h1021 || rx_m !== 16'h1021) begin errors++; $display("FAIL held_crc got=%h/%h exp=1021/1021", calc_m, rx_m); end
        checks++; if (done_m !== 1'b1 || ok_m !== 1'b1 || count_m !== 13'd1) begin errors++; $display("FAIL held_result got=%b%b/%0d exp=11/1", done_m, ok_m, count_m); end
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        sel        = 2'd0;
        repeat (3) @(negedge clk);
        test_reset();
        test_check_vector();
        test_start_ignored();
        test_restart_from_done();
        test_all_ff();
        test_held_valid();
        checks++; if (timeouts !== 0) begin errors++; $display("FAIL handshake_timeouts got=%0d exp=0", timeouts); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
